result_to_bcd: RTL and testbench
================================

# result_to_bcd

Sequential binary-to-BCD converter that sits directly downstream of the integer divider. It captures the divider's unsigned quotient and sign bit on a start pulse and converts the magnitude with the shift-and-add-3 method, one bit per clock. It presents registered BCD digits, a sign flag and a leading-zero blank mask to the seven-segment display driver.

## Interface
- numBits, default 8: width of the quotient magnitude; must match the divider's numBits.
- DIGITS, default 3: number of BCD digits produced; must satisfy 10^DIGITS > 2^numBits − 1 (elaboration-time check, fatal on violation).
- clk  input  1: single clock; all state changes on the rising edge.
- rst  input  1: asynchronous, active-high reset.
- start  input  1: request a conversion; sampled only in IDLE.
- value  input  numBits: quotient magnitude (divider result).
- sign  input  1: quotient sign (divider sign output; 1 = negative).
- busy  output  1: high from the cycle after an accepted start through the DONE cycle, inclusive.
- done  output  1: one-cycle pulse; outputs below are valid from this cycle on.
- bcd  output  4*DIGITS: digit k in bits [4k+3:4k]; digit 0 is the least significant.
- neg  output  1: registered sign; forced to 0 when the converted value is zero.
- blank  output  DIGITS: bit k = 1 when digit k is a leading zero; bit 0 is always 0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - When start = 1, latch value into a numBits shift register and sign into a sign register.
  - Clear the scratch BCD register to 0.
  - Load the bit counter with numBits and go to SHIFT.
- SHIFT, each cycle:
  - Every scratch digit ≥ 5 gets +3 (4-bit add; the result never exceeds 12).
  - Then shift {scratch, operand} left by one, so the operand MSB enters digit 0 LSB.
  - Decrement the counter. When the counter reaches 1 in this cycle, go to DONE.
- DONE (exactly one cycle):
  - Copy scratch to bcd.
  - Compute blank from bcd scanning downward from the most significant digit.
  - Set neg = latched sign & (converted value ≠ 0).
  - Pulse done and return to IDLE.
- bcd, neg and blank hold their last values until the next DONE.
- start while busy is ignored; it is not queued.
- start high in the DONE cycle is ignored. start in the following IDLE cycle is accepted, giving a minimum issue interval of numBits+2 cycles.
- value and sign need to be stable only in the cycle start is sampled.
- Operand 0: bcd = all zeros, blank = all ones except bit 0, neg = 0 regardless of sign (no "-0").

## Timing
- Start accepted at edge E. SHIFT occupies edges E+1..E+numBits. DONE is registered at edge E+numBits+1.
- done is high for the single cycle following edge E+numBits+1. Latency is numBits+1 clocks (9 for the defaults).
- busy rises after edge E and falls after edge E+numBits+2.
- Reset values:
  - State: IDLE.
  - busy = 0, done = 0, bcd = 0, neg = 0.
  - blank = all ones except bit 0.
  - Internal registers: 0.
- Reset asserted mid-conversion aborts it immediately. No done is produced and outputs return to reset values.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - The state enumeration (IDLE, SHIFT, DONE).
  - The BCD digit width constant (4).
  - A function returning the minimum DIGITS for a given numBits, used by the elaboration check.
- One sub-module, bcd_add3: 4-bit combinational digit adjust (in ≥ 5 ? in+3 : in), instantiated DIGITS times in a generate loop.
- The top module contains the FSM, counter, shift registers and output registers.

## Test plan
- value=255, sign=0, start pulse → done exactly 9 cycles later; bcd digits 2,5,5; neg=0; blank=000.
- value=100, sign=1 → bcd 1,0,0; neg=1; blank=000.
- value=7, sign=1 → bcd 0,0,7; neg=1; blank=110 (bits 2..0).
- value=0, sign=1 → bcd 0,0,0; neg=0; blank=110.
- Issue value=42, then assert start with value=99 at cycle 3 of SHIFT → second request ignored; result 0,4,2; only one done pulse. A start issued in the cycle after done converts 99 correctly.
- Start value=200, assert rst in cycle 4 of SHIFT → all outputs return to reset values immediately; no done. After release, value=13 converts to 0,1,3.

Source files
------------

// File: rtl/result_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states, the digit
// width, and a helper that gives the minimum digit count for a given
// magnitude width. Used by the top-level elaboration check.
package result_to_bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest d such that 10^d > 2^nbits - 1 (valid for nbits up to 63).
    function automatic int min_digits(input int nbits);
        longint unsigned maxv;
        longint unsigned p;
        int              d;
        maxv = (longint'(1) << nbits) - 1;
        p    = 10;
        d    = 1;
        for (int i = 0; i < 20; i++) begin
            if (p <= maxv) begin
                p = p * 10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/result_to_bcd_if.sv
// Request/result bundle between the divider side and the BCD converter.
// master: drives start/value/sign, receives busy/done/bcd/neg/blank.
// slave:  the converter, the reverse directions.
interface result_to_bcd_if #(
    parameter int numBits = 8,
    parameter int DIGITS  = 3
);
    logic                  start;
    logic [numBits-1:0]    value;
    logic                  sign;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, value, sign,
        input  busy, done, bcd, neg, blank
    );

    modport slave (
        input  start, value, sign,
        output busy, done, bcd, neg, blank
    );
endinterface

// File: rtl/result_to_bcd_add3.sv
// Single-digit adjust for shift-and-add-3: adds 3 to any digit >= 5.
// Ports: din (4-bit BCD digit), dout (adjusted digit).
// Purely combinational; input never exceeds 9 so the sum never exceeds 12.
module bcd_add3
    import result_to_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);
    assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;
endmodule

// File: rtl/result_to_bcd.sv
// Sequential binary-to-BCD converter (one operand bit per clock), with sign
// flag and leading-zero blank mask. Ports: clk, rst (async active-high), bus
// (slave side of result_to_bcd_if). Latency numBits+1 clocks; start ignored while busy.
module result_to_bcd
    import result_to_bcd_pkg::*;
#(
    parameter int numBits = 8,
    parameter int DIGITS  = 3
) (
    input  logic           clk,
    input  logic           rst,
    result_to_bcd_if.slave bus
);
    localparam int CW = $clog2(numBits + 1);
    localparam int SW = BCD_W * DIGITS;
    // Leading-zero mask of a zero result: every digit blank except digit 0.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    if (DIGITS < min_digits(numBits)) begin : g_bad_digits
        $fatal(1, "result_to_bcd: DIGITS too small for numBits");
    end

    state_t              state;
    logic [numBits-1:0]  opnd;
    logic                sgn;
    logic [SW-1:0]       scratch;
    logic [SW-1:0]       adj;
    logic [CW-1:0]       cnt;
    logic                busy_q;
    logic                done_q;
    logic [SW-1:0]       bcd_q;
    logic                neg_q;
    logic [DIGITS-1:0]   blank_q;
    logic [DIGITS-1:0]   blank_nxt;
    logic                lead;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[g*BCD_W +: BCD_W]),
            .dout (adj[g*BCD_W +: BCD_W])
        );
    end

    // A digit is blank only if it and every digit above it are zero;
    // digit 0 is always shown.
    always_comb begin
        blank_nxt = '0;
        lead      = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead         = lead & (scratch[k*BCD_W +: BCD_W] == '0);
            blank_nxt[k] = lead;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            opnd    <= '0;
            sgn     <= 1'b0;
            scratch <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            blank_q <= BLANK_RST;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= bus.start;
                    if (bus.start) begin
                        opnd    <= bus.value;
                        sgn     <= bus.sign;
                        scratch <= '0;
                        cnt     <= CW'(numBits);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Adjusted digits and operand shift as one register;
                    // operand MSB lands in digit 0 LSB.
                    {scratch, opnd} <= {adj, opnd} << 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= scratch;
                    blank_q <= blank_nxt;
                    neg_q   <= sgn & (|scratch);
                    done_q  <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
    assign bus.neg   = neg_q;
    assign bus.blank = blank_q;
endmodule

// File: tb/tb_result_to_bcd.sv
// Self-checking bench for result_to_bcd: directed cases, busy/ignore and
// mid-conversion reset scenarios, then random operands against a decimal
// arithmetic reference model.
module tb_result_to_bcd;
    localparam int NB = 8;
    localparam int DG = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    result_to_bcd_if #(.numBits(NB), .DIGITS(DG)) bus ();

    result_to_bcd #(.numBits(NB), .DIGITS(DG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: digits from decimal arithmetic.
    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int k = 0; k < DG; k++) begin
            r[k*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference: digit k is a leading zero when the value is below 10^k.
    function automatic logic [31:0] ref_blank(input int v);
        logic [31:0] r;
        int          p;
        r = '0;
        p = 10;
        for (int k = 1; k < DG; k++) begin
            r[k] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current negedge and check the result.
    task automatic convert(input int v, input logic s);
        int n;
        bus.value = NB'(v);
        bus.sign  = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.value = NB'($urandom);   // operand only needs to be stable at accept
        bus.sign  = ~s;
        check("busy_rise", 32'(bus.busy), 32'd1);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (bus.done) break;
        end
        check($sformatf("latency v=%0d", v), 32'(n), 32'd9);
        check($sformatf("bcd v=%0d", v), 32'(bus.bcd), ref_bcd(v));
        check($sformatf("neg v=%0d", v), 32'(bus.neg), 32'(s && v != 0));
        check($sformatf("blank v=%0d", v), 32'(bus.blank), ref_blank(v));
        check("busy_in_done", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("done_pulse_end", 32'(bus.done), 32'd0);
        check("busy_fall", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(bus.busy),  32'd0);
        check({tag, "_done"},  32'(bus.done),  32'd0);
        check({tag, "_bcd"},   32'(bus.bcd),   32'd0);
        check({tag, "_neg"},   32'(bus.neg),   32'd0);
        check({tag, "_blank"}, 32'(bus.blank), 32'b110);
    endtask

    initial begin
        int n;
        int dones;
        bus.start = 1'b0;
        bus.value = '0;
        bus.sign  = 1'b0;

        // Reset state.
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        convert(255, 1'b0);
        convert(100, 1'b1);
        convert(7, 1'b1);
        convert(0, 1'b1);

        // Start during SHIFT is ignored.
        bus.value = 8'd42;
        bus.sign  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.value = 8'd99;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 3;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (bus.done) break;
        end
        check("ignore_latency", 32'(n), 32'd9);
        check("ignore_bcd", 32'(bus.bcd), ref_bcd(42));
        @(negedge clk);
        check("ignore_single_done", 32'(bus.done), 32'd0);
        convert(99, 1'b0);

        // Reset mid-conversion.
        bus.value = 8'd200;
        bus.sign  = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midreset_no_done", 32'(dones), 32'd0);
        check("midreset_idle_busy", 32'(bus.busy), 32'd0);
        convert(13, 1'b0);

        // Random operands.
        for (int i = 0; i < 24; i++) begin
            convert(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
